design_reset_sequencer: RTL
===========================

DESIGN_RESET_SEQUENCER -- requirements
Module: design_reset_sequencer

Interface
REQ-001 Parameter NUM_PROJECTS, default 13: number of selectable designs, indexed 1..NUM_PROJECTS.
REQ-002 Parameter HOLD_CYCLES, default 8, legal range 1..255: number of clock cycles a newly selected design is held in reset before release.
REQ-003 clk  input  1: single clock; all state is updated on its rising edge.
REQ-004 n_rst  input  1: reset, asynchronous, active-low.
REQ-005 designs_cs  input  [NUM_PROJECTS:1]: active-low chip selects from the design-select decoder; at most one bit is low in legal operation.
REQ-006 designs_n_rst  output  [NUM_PROJECTS:1]: registered active-low reset, one bit per design.
REQ-007 busy  output  1: high while the sequencer is in HOLD, meaning a reset is being applied or counted.

Function
REQ-008 The block SHALL register designs_cs into cs_q on every clock; cs_q is the only source of the selection.
REQ-009 sel_q SHALL be derived from cs_q as the index of the single low bit; zero or more than one low bit SHALL decode as "none" (value 0).
REQ-010 States SHALL be HOLD and RUN; active_q SHALL hold the selection currently being served.
REQ-011 HOLD: all designs_n_rst bits 0, busy 1, counter cnt decrements by one per clock.
REQ-012 HOLD with cnt==0 SHALL transition to RUN on that edge and drive designs_n_rst[active_q]=1 from the same edge; all other bits remain 0.
REQ-013 RUN with active_q == "none" SHALL hold all designs_n_rst bits 0 and drive busy 0.
REQ-014 RUN with sel_q != active_q SHALL on the next edge enter HOLD: active_q<=sel_q, cnt<=HOLD_CYCLES-1, all designs_n_rst bits <=0.
REQ-015 HOLD with sel_q != active_q SHALL restart: active_q<=sel_q, cnt<=HOLD_CYCLES-1; the earlier countdown is discarded.
REQ-016 Latency: a designs_cs change stable from edge E SHALL assert all resets low at edge E+2 and release the new design at edge E+1+HOLD_CYCLES+1.
REQ-017 A change to "none" SHALL still pass through HOLD and then RUN with all resets low.
REQ-018 At no clock SHALL more than one designs_n_rst bit be 1.
REQ-019 A deselected design SHALL see its reset asserted no later than the edge on which any other design could be released.
REQ-020 The cnt width SHALL be 8 bits; cnt SHALL never wrap below 0.

Reset
REQ-021 n_rst low SHALL asynchronously force designs_n_rst all 0, busy 1, state HOLD, cnt HOLD_CYCLES-1, cs_q all 1s, active_q "none".
REQ-022 The deassertion of n_rst SHALL pass through a 2-flop synchronizer; the synchronized reset SHALL asynchronously reset all FSM registers, and its release is synchronous to clk.
REQ-023 Reset asserted mid-HOLD or mid-RUN SHALL take effect without waiting for a clock edge.

Structure
REQ-024 A shared package SHALL hold the state enum (HOLD, RUN) and the default constants for NUM_PROJECTS and HOLD_CYCLES.
REQ-025 One sub-module, reset_sync, SHALL implement the 2-flop reset synchronizer (asynchronous assert, synchronous deassert).
REQ-026 The implementation SHALL be a drop-in replacement for the existing reset-routing position, connected with the ports clk, n_rst, designs_cs and designs_n_rst.

Verification
REQ-027 Reset with designs_cs all 1s, then release -> busy falls after 2 (synchronizer) + HOLD_CYCLES edges; all designs_n_rst bits remain 0.
REQ-028 HOLD_CYCLES=4, designs_cs[3]=0 stable from edge E -> designs_n_rst=0 through edge E+5; designs_n_rst[3]=1 at edge E+6.
REQ-029 Running design 3, switch to design 5 -> bit 3 falls at E+2; bit 5 rises at E+6; bits 3 and 5 are never high together.
REQ-030 Select changes again during HOLD (3 to 5, then 7 two cycles later) -> countdown restarts; only design 7 is released, 4 cycles after restart; design 5 is never released.
REQ-031 Illegal designs_cs with bits 2 and 4 both low -> treated as "none"; all resets stay 0.
REQ-032 n_rst pulsed low mid-RUN between clock edges -> designs_n_rst all 0 immediately; the sequence restarts from REQ-021 state after release.

Source files
------------

// File: rtl/design_reset_sequencer_pkg.sv
// Shared types and defaults for the design reset sequencer.
// Holds the FSM state encoding and parameter defaults.
package design_reset_sequencer_pkg;

  localparam int DEF_NUM_PROJECTS = 13;
  localparam int DEF_HOLD_CYCLES  = 8;
  localparam int CNT_W            = 8;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/design_reset_sequencer_reset_sync.sv
// Two-flop reset synchronizer for the sequencer.
// Asserts asynchronously, releases on the second clock edge.
module reset_sync (
  input  logic clk,
  input  logic n_rst,
  output logic rst_n
);

  logic ff1;
  logic ff2;

  // Shift a constant one through two flops after release
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ff1 <= 1'b0;
      ff2 <= 1'b0;
    end else begin
      ff1 <= 1'b1;
      ff2 <= ff1;
    end
  end

  assign rst_n = ff2;

endmodule

// File: rtl/design_reset_sequencer.sv
// Routes a held-then-released reset to the selected design.
// Only one design is ever out of reset at a time.
module design_reset_sequencer
  import design_reset_sequencer_pkg::*;
#(
  parameter int NUM_PROJECTS = DEF_NUM_PROJECTS,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [NUM_PROJECTS:1] designs_cs,
  output logic [NUM_PROJECTS:1] designs_n_rst,
  output logic                  busy
);

  localparam int SW = $clog2(NUM_PROJECTS + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLD_CYCLES - 1);

  logic                  rst_sync;
  logic [NUM_PROJECTS:1] cs_q;
  logic [SW-1:0]         sel_d;
  logic [SW-1:0]         sel_q;
  logic [SW-1:0]         active_q;
  logic [CNT_W-1:0]      cnt;
  state_e                state;
  logic [NUM_PROJECTS:1] rel;
  int                    zeros;

  reset_sync u_reset_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .rst_n (rst_sync)
  );

  // Register the raw chip selects
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) cs_q <= '1;
    else           cs_q <= designs_cs;
  end

  // Decode a single low select; anything else means none
  always_comb begin
    sel_d = '0;
    zeros = 0;
    for (int i = 1; i <= NUM_PROJECTS; i++) begin
      if (!cs_q[i]) begin
        zeros = zeros + 1;
        sel_d = SW'(i);
      end
    end
    if (zeros != 1) sel_d = '0;
  end

  // Register the decoded selection
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) sel_q <= '0;
    else           sel_q <= sel_d;
  end

  // One-hot release pattern for the design being served
  always_comb begin
    rel = '0;
    for (int i = 1; i <= NUM_PROJECTS; i++) begin
      rel[i] = (active_q == SW'(i));
    end
  end

  // Hold/run sequencing; a new selection always restarts the hold
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state         <= HOLD;
      cnt           <= CNT_INIT;
      active_q      <= '0;
      designs_n_rst <= '0;
    end else begin
      unique case (state)
        HOLD: begin
          if (sel_q != active_q) begin
            active_q <= sel_q;
            cnt      <= CNT_INIT;
          end else if (cnt == '0) begin
            state         <= RUN;
            designs_n_rst <= rel;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RUN: begin
          if (sel_q != active_q) begin
            state         <= HOLD;
            active_q      <= sel_q;
            cnt           <= CNT_INIT;
            designs_n_rst <= '0;
          end
        end
        default: begin
          state         <= HOLD;
          designs_n_rst <= '0;
        end
      endcase
    end
  end

  assign busy = (state == HOLD);

endmodule
